imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Sequences a writable instruction RAM between a program loader and the RISC-V core's fetch port.
//  Holds the core stalled and in reset while a word stream is written at incrementing addresses.
//  Releases the core to fetch from word 0 once loading completes.
//  Sits between the bench/UART loader, the instruction RAM write port and the core's PC/reset.
// PARAMETERS
//  DEPTH   32  number of 32-bit instruction words in the RAM (power of 2, >=4)
//  AW      $clog2(DEPTH)  word-address width (derived, not overridden)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  load_start   in   1   pulse: begin a new program load (honoured in BOOT and RUN)
//  ld_valid     in   1   loader word valid
//  ld_data      in   32  loader instruction word
//  ld_last      in   1   qualifies ld_data as final word of the program
//  ld_ready     out  1   controller accepts word this cycle
//  mem_we       out  1   RAM write enable
//  mem_waddr    out  AW  RAM word write address
//  mem_wdata    out  32  RAM write data
//  cpu_addr     in   32  core fetch byte address (PC)
//  mem_raddr    out  AW  RAM word read address = cpu_addr[AW+1:2]
//  cpu_rst_n    out  1   core reset, low while not in RUN
//  fetch_err    out  1   RUN only: cpu_addr[1:0]!=0 or cpu_addr>=4*DEPTH
//  load_cnt     out  AW+1 words written by the last/current load
// BEHAVIOUR
//  States: BOOT, LOAD, FLUSH, RUN (+CLEAR with IMEM_CLEAR_EN).
//  Reset values: state=BOOT, ld_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst_n=0, fetch_err=0, load_cnt=0.
//  BOOT: cpu_rst_n=0. load_start -> LOAD, with waddr counter=0 and load_cnt=0.
//  LOAD: ld_ready=1. On ld_valid&&ld_ready, next cycle has mem_we=1, mem_waddr=counter, mem_wdata=ld_data.
//    Write is registered, 1-cycle latency; counter++ and load_cnt++ on the same accepting edge.
//    Accepted word with ld_last=1, or accepted word at counter==DEPTH-1 -> FLUSH.
//  FLUSH: exactly 1 cycle, ld_ready=0, lets the final write retire; then -> RUN.
//  RUN: cpu_rst_n=1 (registered, rises the cycle after FLUSH). fetch_err is combinational on cpu_addr.
//    load_start in RUN -> LOAD: cpu_rst_n=0 on the next cycle, counter cleared.
//  mem_raddr is always driven from cpu_addr (combinational) regardless of state.
//  load_start during LOAD/FLUSH: ignored.
//  Words offered after ld_last or after DEPTH is reached: never accepted (ld_ready=0).
//  load_cnt saturates at DEPTH and holds its value through RUN.
//  Async reset mid-load: everything returns to BOOT immediately.
//    RAM contents are untouched; the core stays in reset until a new load completes.
//  No write ever occurs outside LOAD/CLEAR, so there is no read/write conflict while cpu_rst_n=1.
// CONFIGURATION
//  IMEM_CLEAR_EN defined: after FLUSH, if load_cnt<DEPTH, enter CLEAR.
//    CLEAR writes NOP 32'h00000013 to words load_cnt..DEPTH-1, one per cycle (mem_we=1), then -> RUN.
//    load_cnt is not changed by CLEAR.
//  IMEM_CLEAR_EN undefined: FLUSH -> RUN directly; unloaded words keep their prior contents.
// STRUCTURE
//  Package imem_pkg: typedef enum logic [2:0] imem_ld_state_t {BOOT,LOAD,FLUSH,CLEAR,RUN};
//    localparam logic [31:0] RV_NOP = 32'h00000013; localparam IMEM_DEPTH = 32.
//  Single module, no sub-module needed.
//  The RAM itself is instantiated beside this block, not inside it.
// TESTING
//  1 Reset, then load_start + 4 words (last on word 4) -> mem_we at addr 0..3 with matching data;
//    FLUSH; cpu_rst_n=1 two cycles after last accept; load_cnt=4.
//  2 Load 32 words with ld_last never set -> stop after addr 31; 33rd word sees ld_ready=0; load_cnt=32; RUN.
//  3 RUN, cpu_addr=0x0000000C -> mem_raddr=3, fetch_err=0.
//    cpu_addr=0x0000000E -> fetch_err=1; cpu_addr=0x00000080 -> fetch_err=1.
//  4 reset_n low after 2 of 5 words -> immediate BOOT, cpu_rst_n=0.
//    A new load of 3 words writes addr 0..2; load_cnt=3.
//  5 load_start in RUN -> cpu_rst_n=0 next cycle, reload 2 words to addr 0,1, RUN again.
//    load_start pulsed mid-LOAD is ignored.
//  6 With IMEM_CLEAR_EN, load 3 words -> writes of 0x00000013 to addr 3..31 (29 cycles), then cpu_rst_n=1.
//    Without the macro -> RUN right after FLUSH.

Source files
------------

// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory load controller:
//   imem_ld_state_t  controller state encoding (BOOT, LOAD, FLUSH, CLEAR, RUN)
//   RV_NOP           RISC-V canonical NOP (addi x0, x0, 0) used to fill unloaded words
//   IMEM_DEPTH       default number of 32-bit words in the instruction RAM
// ----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        CLEAR = 3'd3,
        RUN   = 3'd4
    } imem_ld_state_t;

    localparam logic [31:0] RV_NOP     = 32'h0000_0013;
    localparam int          IMEM_DEPTH = 32;

endpackage : imem_pkg

// File: rtl/imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// imem_load_ctrl
// Sequences a writable instruction RAM between a program loader and the core's
// fetch port. While a program is streamed in, the core is held in reset; once
// the final word has been written the core is released to fetch from word 0.
//
// Optional feature: define IMEM_CLEAR_EN to fill every word beyond the loaded
// program with NOPs before the core is released.
//
// Ports
//   clk          single clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   load_start   pulse: begin a new program load (honoured in BOOT and RUN)
//   ld_valid     loader word valid
//   ld_data      loader instruction word
//   ld_last      marks ld_data as the final word of the program
//   ld_ready     controller accepts a word this cycle
//   mem_we       RAM write enable (registered)
//   mem_waddr    RAM word write address (registered)
//   mem_wdata    RAM write data (registered)
//   cpu_addr     core fetch byte address (PC)
//   mem_raddr    RAM word read address, cpu_addr[AW+1:2]
//   cpu_rst_n    core reset, low while not in RUN
//   fetch_err    RUN only: misaligned or out-of-range fetch address
//   load_cnt     words written by the last/current load
// ----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter  int DEPTH = IMEM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   cpu_addr,
    output logic [AW-1:0] mem_raddr,
    output logic          cpu_rst_n,
    output logic          fetch_err,
    output logic [AW:0]   load_cnt
);

    localparam logic [2:0]  ST_BOOT    = BOOT;
    localparam logic [2:0]  ST_LOAD    = LOAD;
    localparam logic [2:0]  ST_FLUSH   = FLUSH;
    localparam logic [2:0]  ST_RUN     = RUN;
`ifdef IMEM_CLEAR_EN
    localparam logic [2:0]  ST_CLEAR   = CLEAR;
    localparam logic [AW:0] WPTR_FULL  = (AW+1)'(DEPTH);
`endif
    localparam logic [AW:0] WPTR_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;          // next word address to be written
    logic [AW:0]   load_cnt_q, load_cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cpu_rst_n_q;
    logic          accept;
    logic          clr_issue;               // issue one NOP fill write this cycle

    assign ld_ready = (state_q == ST_LOAD);
    assign accept   = ld_ready && ld_valid;

    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        load_cnt_d = load_cnt_q;
        clr_issue  = 1'b0;
        case (state_q)
            ST_BOOT, ST_RUN: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    wptr_d     = '0;
                    load_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wptr_d     = wptr_q + 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    // RAM full also ends the load, which caps load_cnt at DEPTH.
                    if (ld_last || wptr_q == WPTR_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
`ifdef IMEM_CLEAR_EN
                // The first fill write is issued from FLUSH so that the last
                // registered fill write retires inside CLEAR, never in RUN.
                if (load_cnt_q < WPTR_FULL) begin
                    state_d   = ST_CLEAR;
                    clr_issue = 1'b1;
                    wptr_d    = wptr_q + 1'b1;
                end
`endif
            end
`ifdef IMEM_CLEAR_EN
            ST_CLEAR: begin
                if (wptr_q == WPTR_FULL) begin
                    state_d = ST_RUN;
                end else begin
                    clr_issue = 1'b1;
                    wptr_d    = wptr_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_BOOT;
        endcase
    end

    // Write port: one-cycle registered pipeline; address/data hold when idle.
    assign we_d    = accept || clr_issue;
    assign waddr_d = we_d ? wptr_q[AW-1:0] : waddr_q;
    assign wdata_d = accept ? ld_data : (clr_issue ? RV_NOP : wdata_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            wptr_q      <= '0;
            load_cnt_q  <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            load_cnt_q  <= load_cnt_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            // Registered from next state: high exactly while state_q is RUN.
            cpu_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign load_cnt  = load_cnt_q;

    // Fetch side is purely combinational on the PC.
    assign mem_raddr = cpu_addr[AW+1:2];
    assign fetch_err = (state_q == ST_RUN) &&
                       ((cpu_addr[1:0] != 2'b00) || (cpu_addr >= ADDR_LIMIT));

endmodule : imem_load_ctrl

// File: tb/tb_imem_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Self-checking bench for imem_load_ctrl. Keeps a word-level model of the
// instruction RAM and of the expected write sequence, derived from the
// loading rules (words accepted until ld_last or RAM full, optional NOP fill),
// and compares the DUT's write port, handshake, reset release and fetch
// decode against it.
// ----------------------------------------------------------------------------
module tb_imem_load_ctrl;

    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   cpu_addr = '0;
    logic [AW-1:0] mem_raddr;
    logic          cpu_rst_n;
    logic          fetch_err;
    logic [AW:0]   load_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0]    model_mem [DEPTH];
    logic [31:0]    shadow    [DEPTH];
    logic [AW+31:0] got_q [$];
    logic [AW+31:0] exp_q [$];

    imem_load_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_addr   (cpu_addr),
        .mem_raddr  (mem_raddr),
        .cpu_rst_n  (cpu_rst_n),
        .fetch_err  (fetch_err),
        .load_cnt   (load_cnt)
    );

    always #5 clk = ~clk;

    // Behaves like the RAM beside the controller and logs every write.
    always @(posedge clk) begin
        if (mem_we) begin
            shadow[mem_waddr] = mem_wdata;
            got_q.push_back({mem_waddr, mem_wdata});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem();
        for (int a = 0; a < DEPTH; a++) begin
            check($sformatf("mem[%0d]", a), 64'(shadow[a]), 64'(model_mem[a]));
        end
    endtask

    // Runs one program load from BOOT/RUN through to RUN.
    // last_at < 0: ld_last never set; mid_start >= 0: pulse load_start with that word.
    // extra: offer one more word during FLUSH, which must be refused.
    task automatic do_load(input int n_words, input int last_at, input int mid_start,
                           input bit extra);
        int          exp_cnt;
        int          cyc;
        logic [31:0] d;
        exp_cnt = (last_at >= 0 && last_at < n_words) ? last_at + 1 : n_words;
        if (exp_cnt > DEPTH) exp_cnt = DEPTH;
        got_q.delete();
        exp_q.delete();

        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("ld_ready_in_load", 64'(ld_ready), 64'(1));
        check("cpu_rst_n_in_load", 64'(cpu_rst_n), 64'(0));
        check("load_cnt_cleared", 64'(load_cnt), 64'(0));

        for (int i = 0; i < exp_cnt; i++) begin
            d          = $urandom;
            ld_valid   = 1'b1;
            ld_data    = d;
            ld_last    = (i == last_at);
            load_start = (i == mid_start);
            check($sformatf("ld_ready_word%0d", i), 64'(ld_ready), 64'(1));
            model_mem[i] = d;
            exp_q.push_back({AW'(i), d});
            @(posedge clk); #1;
            load_start = 1'b0;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // One cycle after the final accept: FLUSH, final write on the port.
        check("flush_ld_ready", 64'(ld_ready), 64'(0));
        check("flush_mem_we", 64'(mem_we), 64'(1));
        check("flush_waddr", 64'(mem_waddr), 64'(exp_cnt - 1));
        check("flush_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        check("flush_load_cnt", 64'(load_cnt), 64'(exp_cnt));
        if (extra) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            #1;
            check("extra_word_refused", 64'(ld_ready), 64'(0));
            ld_valid = 1'b0;
        end

        if (CLR_EN) begin
            for (int a = exp_cnt; a < DEPTH; a++) begin
                model_mem[a] = NOP;
                exp_q.push_back({AW'(a), NOP});
            end
        end

        cyc = 0;
        while (!cpu_rst_n && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("release_latency", 64'(cyc), 64'(1 + (CLR_EN ? DEPTH - exp_cnt : 0)));
        check("run_load_cnt", 64'(load_cnt), 64'(exp_cnt));
        check("run_ld_ready", 64'(ld_ready), 64'(0));
        check("run_mem_we", 64'(mem_we), 64'(0));
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("write%0d", k), 64'(got_q[k]), 64'(exp_q[k]));
        end
        check_mem();
    endtask

    task automatic check_fetch(input logic [31:0] addr, input bit in_run);
        cpu_addr = addr;
        #1;
        check("mem_raddr", 64'(mem_raddr), 64'((addr >> 2) % DEPTH));
        check("fetch_err", 64'(fetch_err),
              64'(in_run && ((addr % 4 != 0) || (addr >= 4 * DEPTH))));
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            model_mem[a] = 32'hDEAD_0000 + 32'(a);
            shadow[a]    = 32'hDEAD_0000 + 32'(a);
        end

        // Reset values.
        cpu_addr = 32'h0000_0080;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_ready", 64'(ld_ready), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_waddr", 64'(mem_waddr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        check("rst_fetch_err", 64'(fetch_err), 64'(0));
        check("rst_load_cnt", 64'(load_cnt), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b1;
        #1;
        check("boot_refuses_word", 64'(ld_ready), 64'(0));
        check("boot_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        ld_valid = 1'b0;
        @(posedge clk); #1;

        // Four-word program terminated by ld_last.
        do_load(4, 3, -1, 1'b0);

        // Fetch decode in RUN: directed then random addresses.
        check_fetch(32'h0000_000C, 1'b1);
        check_fetch(32'h0000_000E, 1'b1);
        check_fetch(32'h0000_0080, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_fetch(($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                    : 32'($urandom_range(0, 4 * DEPTH + 8)),
                        1'b1);
        end

        // Full-depth load with no ld_last; 33rd word must be refused.
        do_load(33, -1, -1, 1'b1);

        // Async reset part-way through a load.
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid     = 1'b1;
            ld_data      = $urandom;
            model_mem[i] = ld_data;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        @(posedge clk); #1;
        cpu_addr = 32'h0000_0080;
        ld_valid = 1'b1;
        reset_n  = 1'b0;
        #1;
        check("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'(0));
        check("midrst_ld_ready", 64'(ld_ready), 64'(0));
        check("midrst_mem_we", 64'(mem_we), 64'(0));
        check("midrst_load_cnt", 64'(load_cnt), 64'(0));
        check("midrst_fetch_err", 64'(fetch_err), 64'(0));
        ld_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("boot_holds_core", 64'(cpu_rst_n), 64'(0));
        check_mem();
        do_load(3, 2, -1, 1'b0);

        // Reload from RUN; load_start pulsed mid-load must be ignored.
        do_load(2, 1, 1, 1'b0);
        check_fetch(32'h0000_0004, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imem_load_ctrl
